// File: rtl/red_pitaya_adc_pkg.sv
// Shared helpers for the ADC capture front-end: code conversion, overrange
// limits and derived widths.
package red_pitaya_adc_pkg;

    localparam int unsigned ADC_DATA_WIDTH_DEF = 14;
    localparam int unsigned NUM_CH_DEF         = 2;
    localparam int unsigned MAX_DEC_LOG2_DEF   = 4;
    localparam int unsigned CNT_WIDTH_DEF      = 32;

    // Accumulator holds the sum of 2^dmax samples without overflow.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned dmax);
        return w + dmax;
    endfunction

    function automatic int unsigned dec_width(input int unsigned dmax);
        return (dmax > 0) ? $clog2(dmax + 1) : 1;
    endfunction

    function automatic logic [31:0] max_code(input int unsigned w);
        return 32'((64'd1 << (w - 1)) - 64'd1);
    endfunction

    function automatic logic [31:0] min_code(input int unsigned w);
        return 32'(64'd1 << (w - 1));
    endfunction

    // Inverted offset binary to two's complement: keep MSB, invert the rest.
    function automatic logic [31:0] to_twos(input logic [31:0] raw, input int unsigned w);
        return raw ^ max_code(w);
    endfunction

endpackage

// File: rtl/red_pitaya_adc_frontend_if.sv
// ADC sample/config bus between the capture front-end and its environment.
interface red_pitaya_adc_frontend_if
    import red_pitaya_adc_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned MAX_DEC_LOG2   = 4,
    parameter int unsigned CNT_WIDTH      = 32
);
    localparam int unsigned DEC_W = dec_width(MAX_DEC_LOG2);

    logic [NUM_CH*ADC_DATA_WIDTH-1:0] adc_dat_i;
    logic                             cfg_enable;
    logic [DEC_W-1:0]                 cfg_dec_log2;
    logic                             ovr_clr;
    logic                             adc_csn;
    logic [NUM_CH*ADC_DATA_WIDTH-1:0] m_dat_o;
    logic                             m_valid_o;
    logic [NUM_CH-1:0]                ovr_o;
    logic [NUM_CH-1:0]                ovr_sticky_o;
    logic [CNT_WIDTH-1:0]             sample_cnt_o;

    modport master (
        output adc_dat_i, cfg_enable, cfg_dec_log2, ovr_clr,
        input  adc_csn, m_dat_o, m_valid_o, ovr_o, ovr_sticky_o, sample_cnt_o
    );

    modport slave (
        input  adc_dat_i, cfg_enable, cfg_dec_log2, ovr_clr,
        output adc_csn, m_dat_o, m_valid_o, ovr_o, ovr_sticky_o, sample_cnt_o
    );

endinterface

// File: rtl/red_pitaya_adc_frontend_ch_decimator.sv
// One ADC channel: input conversion register, overrange flags, boxcar
// accumulator and averaged output register.
module adc_ch_decimator
    import red_pitaya_adc_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned MAX_DEC_LOG2   = 4,
    localparam int unsigned DEC_W = dec_width(MAX_DEC_LOG2)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [ADC_DATA_WIDTH-1:0] i_raw,
    input  logic                      i_en,
    input  logic                      i_first,
    input  logic                      i_last,
    input  logic [DEC_W-1:0]          i_shift,
    input  logic                      i_ovr_clr,
    output logic [ADC_DATA_WIDTH-1:0] o_dat,
    output logic                      o_ovr,
    output logic                      o_ovr_sticky
);
    localparam int unsigned W     = ADC_DATA_WIDTH;
    localparam int unsigned ACC_W = acc_width(ADC_DATA_WIDTH, MAX_DEC_LOG2);

    logic        [W-1:0]     w_conv;
    logic                    w_ovr;
    logic signed [W-1:0]     r_s1;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;
    logic        [W-1:0]     r_dat;
    logic                    r_ovr;
    logic                    r_ovr_sticky;

    // A window start ignores the accumulator so stale partial sums never leak.
    always_comb begin
        w_conv = W'(to_twos(32'(i_raw), W));
        w_ovr  = (w_conv == W'(max_code(W))) || (w_conv == W'(min_code(W)));
        w_sum  = i_first ? ACC_W'(r_s1) : (r_acc + ACC_W'(r_s1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1         <= '0;
            r_acc        <= '0;
            r_dat        <= '0;
            r_ovr        <= 1'b0;
            r_ovr_sticky <= 1'b0;
        end else begin
            r_s1  <= w_conv;
            r_ovr <= w_ovr;
            if (r_ovr)
                r_ovr_sticky <= 1'b1;
            else if (i_ovr_clr)
                r_ovr_sticky <= 1'b0;
            r_acc <= i_en ? w_sum : '0;
            if (i_last)
                r_dat <= W'(w_sum >>> i_shift);
        end
    end

    assign o_dat        = r_dat;
    assign o_ovr        = r_ovr;
    assign o_ovr_sticky = r_ovr_sticky;

endmodule

// File: rtl/red_pitaya_adc_frontend.sv
// Multi-channel ADC capture front-end: shared decimation window control,
// per-channel conversion/averaging and output sample counter.
module red_pitaya_adc_frontend
    import red_pitaya_adc_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH = 14,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned MAX_DEC_LOG2   = 4,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      adc_clk,
    input  logic                      adc_rst,
    red_pitaya_adc_frontend_if.slave  s_bus
);
    localparam int unsigned DEC_W = dec_width(MAX_DEC_LOG2);
    localparam int unsigned PH_W  = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

    logic [DEC_W-1:0]                 w_cfg_clamp;
    logic [DEC_W-1:0]                 w_d_cur;
    logic [DEC_W-1:0]                 r_d_act;
    logic [PH_W-1:0]                  r_ph;
    logic [PH_W-1:0]                  w_ph_last;
    logic                             w_first;
    logic                             w_last;
    logic                             r_valid;
    logic [CNT_WIDTH-1:0]             r_sample_cnt;
    logic [NUM_CH-1:0]                w_ovr;
    logic [NUM_CH-1:0]                w_ovr_sticky;
    logic [NUM_CH*ADC_DATA_WIDTH-1:0] w_dat;

    // At a window start the fresh (clamped) ratio governs this same sample.
    always_comb begin
        w_cfg_clamp = s_bus.cfg_dec_log2;
        if (32'(s_bus.cfg_dec_log2) > MAX_DEC_LOG2)
            w_cfg_clamp = DEC_W'(MAX_DEC_LOG2);
        w_first   = (r_ph == '0);
        w_d_cur   = w_first ? w_cfg_clamp : r_d_act;
        w_ph_last = PH_W'((64'd1 << w_d_cur) - 64'd1);
        w_last    = s_bus.cfg_enable && (r_ph == w_ph_last);
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            r_ph         <= '0;
            r_d_act      <= '0;
            r_valid      <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_valid <= w_last;
            if (!s_bus.cfg_enable) begin
                r_ph <= '0;
            end else begin
                if (w_first)
                    r_d_act <= w_cfg_clamp;
                r_ph <= w_last ? '0 : (r_ph + PH_W'(1));
                if (w_last)
                    r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_ch_decimator #(
            .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
            .MAX_DEC_LOG2   (MAX_DEC_LOG2)
        ) u_ch (
            .i_clk        (adc_clk),
            .i_rst        (adc_rst),
            .i_raw        (s_bus.adc_dat_i[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
            .i_en         (s_bus.cfg_enable),
            .i_first      (w_first),
            .i_last       (w_last),
            .i_shift      (w_d_cur),
            .i_ovr_clr    (s_bus.ovr_clr),
            .o_dat        (w_dat[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
            .o_ovr        (w_ovr[c]),
            .o_ovr_sticky (w_ovr_sticky[c])
        );
    end

    assign s_bus.adc_csn      = 1'b1;
    assign s_bus.m_dat_o      = w_dat;
    assign s_bus.m_valid_o    = r_valid;
    assign s_bus.ovr_o        = w_ovr;
    assign s_bus.ovr_sticky_o = w_ovr_sticky;
    assign s_bus.sample_cnt_o = r_sample_cnt;

endmodule

// File: tb/tb_red_pitaya_adc_frontend.sv
// Directed bench for red_pitaya_adc_frontend: conversion, decimation windows,
// ratio changes, overrange flags, enable/reset behaviour and counter wrap.
module tb_red_pitaya_adc_frontend;
    localparam int unsigned W    = 14;
    localparam int unsigned NCH  = 2;
    localparam int unsigned MAXD = 4;
    localparam int unsigned CW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #4 clk = ~clk;

    red_pitaya_adc_frontend_if #(
        .ADC_DATA_WIDTH(W), .NUM_CH(NCH), .MAX_DEC_LOG2(MAXD), .CNT_WIDTH(CW)
    ) bus ();

    red_pitaya_adc_frontend #(
        .ADC_DATA_WIDTH(W), .NUM_CH(NCH), .MAX_DEC_LOG2(MAXD), .CNT_WIDTH(CW)
    ) dut (
        .adc_clk (clk),
        .adc_rst (rst),
        .s_bus   (bus)
    );

    typedef struct {
        logic [W-1:0] raw;
        int           exp_dat;
        logic         exp_ovr;
    } conv_vec_t;

    typedef struct {
        int s0[4];
        int s1[4];
        int e0;
        int e1;
    } win_vec_t;

    conv_vec_t cv[5];
    win_vec_t  wv[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] raw_of(input int v);
        logic [W-1:0] t;
        t = W'(v);
        return {t[W-1], ~t[W-2:0]};
    endfunction

    task automatic drive(input int v0, input int v1);
        bus.adc_dat_i = {raw_of(v1), raw_of(v0)};
    endtask

    function automatic int dat(input int c);
        logic signed [W-1:0] t;
        t = bus.m_dat_o[c*W +: W];
        return int'(t);
    endfunction

    initial begin
        logic exp_v;

        cv[0] = '{raw: 14'h1FFF, exp_dat: 0,     exp_ovr: 1'b0};
        cv[1] = '{raw: 14'h2000, exp_dat: -1,    exp_ovr: 1'b0};
        cv[2] = '{raw: 14'h0000, exp_dat: 8191,  exp_ovr: 1'b1};
        cv[3] = '{raw: 14'h3FFF, exp_dat: -8192, exp_ovr: 1'b1};
        cv[4] = '{raw: 14'h2ABC, exp_dat: -2749, exp_ovr: 1'b0};

        wv[0] = '{s0: '{100, 101, 102, 103}, s1: '{8191, 8191, 8191, 8191},     e0: 101, e1: 8191};
        wv[1] = '{s0: '{-1, -1, -1, -2},     s1: '{-8192, -8192, -8192, -8192}, e0: -2,  e1: -8192};
        wv[2] = '{s0: '{-5, 3, 0, 7},        s1: '{-1, 0, 0, 0},                e0: 1,   e1: -1};

        bus.adc_dat_i    = {14'h1FFF, 14'h1FFF};
        bus.cfg_enable   = 1'b0;
        bus.cfg_dec_log2 = '0;
        bus.ovr_clr      = 1'b0;

        tick();
        tick();
        chk("rst_dat",    longint'(bus.m_dat_o), 0);
        chk("rst_valid",  longint'(bus.m_valid_o), 0);
        chk("rst_ovr",    longint'(bus.ovr_o), 0);
        chk("rst_sticky", longint'(bus.ovr_sticky_o), 0);
        chk("rst_cnt",    longint'(bus.sample_cnt_o), 0);
        chk("rst_csn",    longint'(bus.adc_csn), 1);
        rst = 1'b0;

        // Conversion table, R=1: ovr one edge after input, data two edges after.
        bus.cfg_enable = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) bus.adc_dat_i = {14'h1FFF, cv[i].raw};
            tick();
            if (i < 5) chk($sformatf("conv_ovr%0d", i), longint'(bus.ovr_o), longint'(cv[i].exp_ovr));
            if (i > 0) begin
                chk($sformatf("conv_valid%0d", i - 1), longint'(bus.m_valid_o), 1);
                chk($sformatf("conv_dat%0d", i - 1), dat(0), cv[i-1].exp_dat);
                chk($sformatf("conv_dat1_%0d", i - 1), dat(1), 0);
            end
        end

        // Back-to-back R=4 windows from a fresh start.
        bus.cfg_enable   = 1'b0;
        bus.cfg_dec_log2 = 3'd2;
        drive(wv[0].s0[0], wv[0].s1[0]);
        tick();
        bus.cfg_enable = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            if (j < 12) drive(wv[j/4].s0[j%4], wv[j/4].s1[j%4]);
            tick();
            exp_v = ((j - 1) % 4 == 3);
            chk($sformatf("dec4_valid%0d", j), longint'(bus.m_valid_o), longint'(exp_v));
            if (exp_v) begin
                chk($sformatf("dec4_dat0_w%0d", (j - 1) / 4), dat(0), wv[(j-1)/4].e0);
                chk($sformatf("dec4_dat1_w%0d", (j - 1) / 4), dat(1), wv[(j-1)/4].e1);
            end
        end

        // Ratio changed 2->0 mid-window: window still completes at R=4.
        bus.cfg_enable   = 1'b0;
        bus.cfg_dec_log2 = 3'd2;
        drive(10, 10);
        tick();
        bus.cfg_enable = 1'b1;
        tick();
        bus.cfg_dec_log2 = 3'd0;
        tick();
        chk("midchg_valid_ph2", longint'(bus.m_valid_o), 0);
        tick();
        chk("midchg_valid_ph3", longint'(bus.m_valid_o), 0);
        tick();
        chk("midchg_valid_end", longint'(bus.m_valid_o), 1);
        chk("midchg_dat",       dat(0), 10);
        tick();
        chk("midchg_r1_valid_a", longint'(bus.m_valid_o), 1);
        tick();
        chk("midchg_r1_valid_b", longint'(bus.m_valid_o), 1);

        // Ratio 7 clamps to 4, i.e. R=16.
        bus.cfg_enable   = 1'b0;
        bus.cfg_dec_log2 = 3'd7;
        drive(10, 10);
        tick();
        bus.cfg_enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("clamp_valid%0d", k), longint'(bus.m_valid_o), longint'(k == 16));
        end
        chk("clamp_dat", dat(0), 10);
        bus.cfg_enable = 1'b0;
        tick();

        // Sticky overrange: set, set-wins-over-clear, clear.
        bus.ovr_clr   = 1'b1;
        bus.adc_dat_i = {14'h1FFF, 14'h1FFF};
        tick();
        tick();
        bus.ovr_clr = 1'b0;
        chk("sticky_cleared0", longint'(bus.ovr_sticky_o), 0);
        bus.adc_dat_i = {14'h1FFF, 14'h0000};
        tick();
        chk("sticky_ovr_now", longint'(bus.ovr_o), 1);
        chk("sticky_not_yet", longint'(bus.ovr_sticky_o), 0);
        bus.adc_dat_i = {14'h1FFF, 14'h1FFF};
        tick();
        chk("sticky_set", longint'(bus.ovr_sticky_o), 1);
        chk("sticky_ovr_gone", longint'(bus.ovr_o), 0);
        bus.adc_dat_i = {14'h1FFF, 14'h3FFF};
        tick();
        chk("sticky_ovr_min", longint'(bus.ovr_o), 1);
        bus.ovr_clr   = 1'b1;
        bus.adc_dat_i = {14'h1FFF, 14'h1FFF};
        tick();
        chk("sticky_set_wins", longint'(bus.ovr_sticky_o), 1);
        tick();
        chk("sticky_clr", longint'(bus.ovr_sticky_o), 0);
        bus.ovr_clr = 1'b0;
        chk("disabled_dat_hold", dat(0), 10);

        // Enable dropped mid-window: partial window discarded, output held.
        bus.cfg_enable   = 1'b0;
        bus.cfg_dec_log2 = 3'd2;
        drive(50, 50);
        tick();
        bus.cfg_enable = 1'b1;
        tick();
        tick();
        bus.cfg_enable = 1'b0;
        drive(60, 60);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("dis_valid%0d", k), longint'(bus.m_valid_o), 0);
            chk($sformatf("dis_dat%0d", k), dat(0), 10);
        end
        bus.cfg_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("reen_valid%0d", k), longint'(bus.m_valid_o), longint'(k == 4));
        end
        chk("reen_dat", dat(0), 60);

        // Reset mid-window clears everything asynchronously.
        bus.adc_dat_i = {14'h0000, raw_of(70)};
        tick();
        tick();
        chk("prerst_sticky", longint'(bus.ovr_sticky_o), 2);
        #1 rst = 1'b1;
        #1;
        chk("arst_dat",    longint'(bus.m_dat_o), 0);
        chk("arst_valid",  longint'(bus.m_valid_o), 0);
        chk("arst_cnt",    longint'(bus.sample_cnt_o), 0);
        chk("arst_ovr",    longint'(bus.ovr_o), 0);
        chk("arst_sticky", longint'(bus.ovr_sticky_o), 0);
        bus.cfg_enable = 1'b0;
        drive(70, 70);
        tick();
        rst = 1'b0;
        tick();
        bus.cfg_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("postrst_valid%0d", k), longint'(bus.m_valid_o), longint'(k == 4));
        end
        chk("postrst_dat", dat(1), 70);
        chk("postrst_cnt", longint'(bus.sample_cnt_o), 1);

        // Counter wrap from a preloaded value, R=1.
        bus.cfg_dec_log2 = 3'd0;
        force dut.r_sample_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_sample_cnt;
        tick();
        chk("wrap_valid", longint'(bus.m_valid_o), 1);
        chk("wrap_max",   longint'(bus.sample_cnt_o), longint'(32'hFFFF_FFFF));
        tick();
        chk("wrap_zero",  longint'(bus.sample_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/red_pitaya_adc_frontend.md
# red_pitaya_adc_frontend

Parametrised multi-channel ADC capture front-end. It registers NUM_CH raw ADC buses on adc_clk and converts each to two's complement. It then applies optional power-of-two boxcar decimation and emits averaged samples with a single-cycle valid strobe, plus per-channel overrange detection. It sits directly behind the ADC clock buffer and feeds all downstream DSP and acquisition logic.

## Interface
- ADC_DATA_WIDTH, 14, bits per channel (raw and output)
- NUM_CH, 2, number of channels packed on the buses
- MAX_DEC_LOG2, 4, largest supported log2 decimation ratio
- CNT_WIDTH, 32, width of output-sample counter
- adc_clk  in  1  sole clock, 125 MHz ADC clock
- adc_rst  in  1  reset, asynchronous, active-high
- adc_dat_i  in  NUM_CH*ADC_DATA_WIDTH  raw ADC codes, channel c at bits [c*W +: W]
- cfg_enable  in  1  capture enable
- cfg_dec_log2  in  $clog2(MAX_DEC_LOG2+1)  decimation ratio R = 2^cfg_dec_log2
- ovr_clr  in  1  clears sticky overrange flags
- adc_csn  out  1  ADC chip select, constant 1
- m_dat_o  out  NUM_CH*ADC_DATA_WIDTH  averaged two's-complement samples, same packing
- m_valid_o  out  1  one-cycle strobe, m_dat_o new
- ovr_o  out  NUM_CH  per-channel overrange on current input sample
- ovr_sticky_o  out  NUM_CH  latched overrange since last clear
- sample_cnt_o  out  CNT_WIDTH  count of m_valid_o pulses, wraps

## Operation
- Stage 1 converts every cycle regardless of cfg_enable: s1[c] <= {raw[W-1], ~raw[W-2:0]}.
- ovr_o[c] registers alongside s1. It is high when the converted value is 2^(W-1)-1 or -2^(W-1).
- ovr_sticky_o[c] is set by ovr_o[c] and cleared by ovr_clr. On a simultaneous set and clear, set wins.
- Decimation window: an active ratio register d_act and a phase counter ph running 0..R-1.
  - d_act loads cfg_dec_log2 only when ph==0 and a sample is accepted, i.e. at a window start.
  - Changes made mid-window take effect at the next window.
  - cfg_dec_log2 values above MAX_DEC_LOG2 clamp to MAX_DEC_LOG2.
- Accumulator per channel is ADC_DATA_WIDTH+MAX_DEC_LOG2 bits, signed, and cannot overflow.
  - At ph==0: acc <= s1.
  - Otherwise: acc <= acc + s1.
  - At ph==R-1: m_dat_o[c] <= (acc + s1) >>> d_act, an arithmetic shift that rounds toward -inf. m_valid_o pulses, sample_cnt_o increments, and ph returns to 0.
- With R=1 every sample passes through unchanged, one valid per cycle.
- When cfg_enable is low:
  - ph and acc are held at 0 and m_valid_o stays 0.
  - m_dat_o and sample_cnt_o hold their values.
  - Overrange logic keeps running.
- On cfg_enable rising, the first accepted sample starts a fresh window.
- There is no backpressure; consumers must take data on m_valid_o.

## Timing
- Reset values: s1, acc, ph, m_dat_o, ovr_o, ovr_sticky_o, sample_cnt_o all 0. m_valid_o is 0. d_act equals cfg_dec_log2 (clamped) at the first window. adc_csn is 1.
- Input on adc_dat_i at edge k appears in s1 after edge k. ovr_o is valid after edge k.
- R=1: sample from edge k gives m_valid_o high after edge k+1, a latency of 2 edges.
- R>1: the last sample of a window, captured at edge k, gives m_valid_o after edge k+1.
  - Steady state gives exactly one m_valid_o every R cycles.
- Reset asserted mid-window: the partial window is discarded and no valid is emitted. After release, counting restarts at ph=0.
- sample_cnt_o wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Structure
- Package red_pitaya_adc_pkg holds:
  - the offset-to-two's-complement conversion function
  - the overrange compare constants (max/min code as functions of width)
  - the accumulator-width and dec-width localparam expressions
- Sub-module adc_ch_decimator, one per channel via generate, contains:
  - stage-1 register
  - overrange flags
  - accumulator
  - output register
- The top owns:
  - the shared ph counter and d_act register
  - sample_cnt_o
  - adc_csn

## Test plan
- Conversion, W=14, R=1, enable=1. Raw 0x1FFF→0, 0x2000→-1, 0x0000→8191, 0x3FFF→-8192. Each appears 2 edges later with m_valid_o high every cycle. ovr_o is high only for the last two.
- Decimation R=4 (dec_log2=2), ch0 converted 100,101,102,103. Expect m_dat_o ch0 = 101, one pulse, then every 4 cycles. Same window with -1,-1,-1,-2 expects -2 (floor).
- cfg_dec_log2 changed 2→0 at ph==1. Current window completes with R=4, then per-cycle output. A value of 7 clamps to R=16.
- Sticky flag: overrange sample sets ovr_sticky_o. ovr_clr in the same cycle as a new overrange leaves it set. ovr_clr alone clears it to 0.
- Enable/reset: deassert enable mid-window, so no valid and m_dat_o holds. Re-enable and the first valid comes after a full R samples. Assert adc_rst mid-window and all outputs return to 0 asynchronously.
- Counter: preload via force near 2^32-1. Expect wrap to 0 on the next m_valid_o.
